// File: rtl/filter_pkg.sv
// filter_pkg: shared mode/state encodings and default parameters for mac_fir_filter
package filter_pkg;
  typedef enum logic [1:0] {
    MODE_BYPASS = 2'b00,
    MODE_FIR    = 2'b01,
    MODE_AVG    = 2'b10,
    MODE_MUTE   = 2'b11
  } mode_t;
  typedef enum logic [1:0] {IDLE, MAC, NORM, DONE} state_t;
  localparam int DEF_SAMPLE_W = 12;
  localparam int DEF_TAPS     = 16;
  localparam int DEF_COEF_W   = 16;
  localparam int DEF_SHIFT    = 7;
endpackage

// File: rtl/mac_fir_filter_if.sv
// mac_fir_filter_if: sample stream, mode select and coefficient write port of mac_fir_filter
interface mac_fir_filter_if import filter_pkg::*; #(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int TAPS     = DEF_TAPS,
  parameter int COEF_W   = DEF_COEF_W
);
  logic signed [SAMPLE_W-1:0]     inSample;
  logic                           inSampleValid;
  logic                           outReady;
  logic [1:0]                     inMode;
  logic                           inCoefWe;
  logic [$clog2(TAPS)-1:0]        inCoefAddr;
  logic signed [COEF_W-1:0]       inCoefData;
  logic signed [SAMPLE_W-1:0]     outSample;
  logic                           outSampleValid;
  modport master (
    output inSample, inSampleValid, inMode, inCoefWe, inCoefAddr, inCoefData,
    input  outReady, outSample, outSampleValid
  );
  modport slave (
    input  inSample, inSampleValid, inMode, inCoefWe, inCoefAddr, inCoefData,
    output outReady, outSample, outSampleValid
  );
endinterface

// File: rtl/filter_mac.sv
// filter_mac: signed multiply-accumulate with synchronous clear and enable
module filter_mac #(
  parameter int A_W   = 12,
  parameter int B_W   = 16,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [ACC_W-1:0] acc
);
  logic signed [A_W+B_W-1:0] prod;
  assign prod = a * b;
  // accumulator: clear wins over enable so a new sample always starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else if (clr) acc <= '0;
    else if (en) acc <= acc + ACC_W'(prod);
  end
endmodule

// File: rtl/mac_fir_filter.sv
// mac_fir_filter: serial one-tap-per-cycle FIR / moving-average filter; FILTER_SATURATE_EN clamps output instead of wrapping
module mac_fir_filter import filter_pkg::*; #(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int TAPS     = DEF_TAPS,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int SHIFT    = DEF_SHIFT
) (
  input logic inClk,
  input logic inRst_n,
  mac_fir_filter_if.slave bus
);
  localparam int PW    = $clog2(TAPS);
  localparam int ACC_W = SAMPLE_W + COEF_W + PW;
  state_t                     state;
  mode_t                      mode;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              k;
  logic [PW-1:0]              rd_ptr;
  logic signed [SAMPLE_W-1:0] hist [TAPS];
  logic signed [COEF_W-1:0]   coef [TAPS];
  logic signed [COEF_W-1:0]   term;
  logic signed [ACC_W-1:0]    acc;
  logic signed [SAMPLE_W-1:0] norm;
  logic signed [SAMPLE_W-1:0] result;
  logic                       ready;
  logic                       valid;
  logic                       accept;
  logic                       slow_mode;
  assign bus.outReady       = ready;
  assign bus.outSampleValid = valid;
  assign bus.outSample      = result;
  assign accept    = bus.inSampleValid && ready;
  assign slow_mode = bus.inMode == MODE_FIR || bus.inMode == MODE_AVG;
  // wr_ptr already points past the newest sample, so tap k reads k steps further back
  assign rd_ptr = wr_ptr - PW'(1) - k;
  assign term   = mode == MODE_FIR ? coef[k] : COEF_W'(1);
`ifdef FILTER_SATURATE_EN
  localparam logic signed [SAMPLE_W-1:0] S_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] S_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};
  logic signed [ACC_W-1:0] shifted;
  assign shifted = acc >>> (mode == MODE_FIR ? SHIFT : PW);
  assign norm = shifted > ACC_W'(S_MAX) ? S_MAX :
                shifted < ACC_W'(S_MIN) ? S_MIN : shifted[SAMPLE_W-1:0];
`else
  assign norm = SAMPLE_W'(acc >>> (mode == MODE_FIR ? SHIFT : PW));
`endif
  filter_mac #(.A_W(SAMPLE_W), .B_W(COEF_W), .ACC_W(ACC_W)) u_mac (
    .clk  (inClk),
    .rst_n(inRst_n),
    .clr  (accept),
    .en   (state == MAC),
    .a    (hist[rd_ptr]),
    .b    (term),
    .acc  (acc)
  );
  // control FSM with registered ready/strobe/result, history and coefficient storage
  always_ff @(posedge inClk or negedge inRst_n) begin
    if (!inRst_n) begin
      state  <= IDLE;
      mode   <= MODE_BYPASS;
      ready  <= 1'b1;
      valid  <= 1'b0;
      result <= '0;
      wr_ptr <= '0;
      k      <= '0;
      for (int i = 0; i < TAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= (i == 0) ? COEF_W'(1 << SHIFT) : '0;
      end
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.inCoefWe) coef[bus.inCoefAddr] <= bus.inCoefData;
          if (accept) begin
            hist[wr_ptr] <= bus.inSample;
            wr_ptr       <= wr_ptr + PW'(1);
            mode         <= mode_t'(bus.inMode);
            k            <= '0;
            ready        <= 1'b0;
            state        <= slow_mode ? MAC : DONE;
            valid        <= !slow_mode;
            if (!slow_mode) result <= bus.inMode == MODE_BYPASS ? bus.inSample : '0;
          end
        end
        MAC: begin
          k <= k + PW'(1);
          if (k == PW'(TAPS - 1)) state <= NORM;
        end
        NORM: begin
          state  <= DONE;
          valid  <= 1'b1;
          result <= norm;
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end
endmodule
